// File: rtl/arm7tdmi_pkg.sv
// arm7tdmi_pkg: shared types and constants for the ARM7TDMI bus initiator
package arm7tdmi_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} mem_size_t;
  typedef enum logic [1:0] {BUS_IDLE, BUS_ACTIVE, BUS_RECOVER} bus_state_t;
  localparam logic [3:0] BE_ALL = 4'hF;
  typedef struct packed {
    logic        is_data;
    logic        we;
    mem_size_t   size;
    logic        sgn;
    logic [31:0] addr;
  } xfer_t;
endpackage

// File: rtl/arm7tdmi_lane_align.sv
// arm7tdmi_lane_align: store byte-lane steering and load alignment/extension
module arm7tdmi_lane_align import arm7tdmi_pkg::*; (
  input  mem_size_t   i_size,
  input  logic [1:0]  i_addr,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [31:0] w_rot;
  logic [15:0] w_half;
  // word rotate doubles as byte selector: the addressed lane lands in [7:0]
  assign w_rot   = 32'({i_rdata, i_rdata} >> {i_addr, 3'b000});
  assign w_half  = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign o_be    = i_size == SZ_BYTE ? 4'b0001 << i_addr : i_size == SZ_HALF ? (i_addr[1] ? 4'hC : 4'h3) : BE_ALL;
  assign o_wdata = i_size == SZ_BYTE ? {4{i_wdata[7:0]}} : i_size == SZ_HALF ? {2{i_wdata[15:0]}} : i_wdata;
  assign o_rdata = i_size == SZ_BYTE ? {{24{i_signed & w_rot[7]}}, w_rot[7:0]} :
                   i_size == SZ_HALF ? {{16{i_signed & w_half[15]}}, w_half} : w_rot;
endmodule

// File: rtl/arm7tdmi_bus_initiator.sv
// arm7tdmi_bus_initiator: arbitrates fetch/data requests onto the single-outstanding mem_* bus
module arm7tdmi_bus_initiator import arm7tdmi_pkg::*; #(
  parameter int TIMEOUT_CYCLES   = 16,
  parameter bit ABORT_ON_TIMEOUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch_req,
  input  logic [31:0] i_fetch_addr,
  output logic        o_fetch_done,
  output logic [31:0] o_fetch_rdata,
  output logic        o_fetch_abort,
  input  logic        i_data_req,
  input  logic        i_data_we,
  input  mem_size_t   i_data_size,
  input  logic        i_data_signed,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_done,
  output logic [31:0] o_data_rdata,
  output logic        o_data_abort,
  output logic [31:0] o_abort_addr,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  output logic        o_mem_re,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  input  logic        i_mem_abort
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  bus_state_t    r_state;
  xfer_t         r_cur;
  logic [CW-1:0] r_cnt;
  xfer_t         w_req;
  mem_size_t     w_sz;
  logic [1:0]    w_a;
  logic          w_accept, w_timeout, w_done, w_abort, w_zero;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_rdata;
  assign w_req = i_data_req ? xfer_t'{1'b1, i_data_we, i_data_size, i_data_signed, i_data_addr}
                            : xfer_t'{1'b0, 1'b0, SZ_WORD, 1'b0, {i_fetch_addr[31:2], 2'b00}};
  assign w_accept  = (r_state == BUS_IDLE || (r_state == BUS_RECOVER && !i_mem_ready)) && (i_data_req || i_fetch_req);
  assign w_timeout = !i_mem_ready && r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign w_done    = r_state == BUS_ACTIVE && (i_mem_ready || w_timeout);
  assign w_abort   = i_mem_ready ? i_mem_abort : ABORT_ON_TIMEOUT;
  assign w_zero    = w_abort || !i_mem_ready;
  // accept and completion never share a cycle, so one aligner serves both directions
  assign w_sz = r_state == BUS_ACTIVE ? r_cur.size : w_req.size;
  assign w_a  = r_state == BUS_ACTIVE ? r_cur.addr[1:0] : w_req.addr[1:0];
  arm7tdmi_lane_align u_align (
    .i_size  (w_sz),
    .i_addr  (w_a),
    .i_signed(r_cur.sgn),
    .i_wdata (i_data_wdata),
    .i_rdata (i_mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state       <= BUS_IDLE;
      r_cur         <= '0;
      r_cnt         <= '0;
      o_fetch_done  <= 1'b0;
      o_fetch_rdata <= '0;
      o_fetch_abort <= 1'b0;
      o_data_done   <= 1'b0;
      o_data_rdata  <= '0;
      o_data_abort  <= 1'b0;
      o_abort_addr  <= '0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_mem_be      <= '0;
      o_mem_re      <= 1'b0;
      o_mem_we      <= 1'b0;
    end else begin
      o_fetch_done <= 1'b0;
      o_data_done  <= 1'b0;
      if (w_accept) begin
        r_state     <= BUS_ACTIVE;
        r_cur       <= w_req;
        r_cnt       <= '0;
        o_mem_addr  <= w_req.size == SZ_HALF ? {w_req.addr[31:1], 1'b0} : w_req.addr;
        o_mem_be    <= w_be;
        o_mem_wdata <= w_req.we ? w_wdata : '0;
        o_mem_re    <= !w_req.we;
        o_mem_we    <= w_req.we;
      end else if (w_done) begin
        r_state      <= BUS_RECOVER;
        o_mem_re     <= 1'b0;
        o_mem_we     <= 1'b0;
        o_fetch_done <= !r_cur.is_data;
        o_data_done  <= r_cur.is_data;
        if (r_cur.is_data) begin
          o_data_rdata <= w_zero || r_cur.we ? '0 : w_rdata;
          o_data_abort <= w_abort;
        end else begin
          o_fetch_rdata <= w_zero ? '0 : i_mem_rdata;
          o_fetch_abort <= w_abort;
        end
        if (w_abort) o_abort_addr <= r_cur.addr;
      end else if (r_state == BUS_ACTIVE) r_cnt <= r_cnt + 1'b1;
      else if (r_state == BUS_RECOVER && !i_mem_ready) r_state <= BUS_IDLE;
    end
endmodule

// File: tb/tb_arm7tdmi_bus_initiator.sv
// tb_arm7tdmi_bus_initiator: table-driven scoreboard bench with a 1-wait responder model
module tb_arm7tdmi_bus_initiator;
  import arm7tdmi_pkg::*;
  typedef struct {
    logic        is_data, we, sgn;
    mem_size_t   size;
    logic [31:0] addr, wdata, bus_addr, bus_wdata, rdata;
    logic [3:0]  be;
    logic        abort;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0, data_signed = 1'b0;
  mem_size_t data_size = SZ_WORD;
  logic [31:0] fetch_addr = '0, data_addr = '0, data_wdata = '0;
  logic fetch_done, fetch_abort, data_done, data_abort, mem_re, mem_we, mem_ready, mem_abort;
  logic [31:0] fetch_rdata, data_rdata, abort_addr, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  logic rsp_ready, rsp_abort, late_ready = 1'b0, hang = 1'b0;
  logic [31:0] rsp_rdata;
  logic [31:0] mem [0:15];
  vec_t tbl [16];
  vec_t q[$];
  int n_checks = 0, n_errors = 0, t_strobe, t_done, strobe_cycles;

  arm7tdmi_bus_initiator dut (
    .clk(clk), .rst(rst),
    .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr), .o_fetch_done(fetch_done),
    .o_fetch_rdata(fetch_rdata), .o_fetch_abort(fetch_abort),
    .i_data_req(data_req), .i_data_we(data_we), .i_data_size(data_size), .i_data_signed(data_signed),
    .i_data_addr(data_addr), .i_data_wdata(data_wdata), .o_data_done(data_done),
    .o_data_rdata(data_rdata), .o_data_abort(data_abort), .o_abort_addr(abort_addr),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_be(mem_be), .o_mem_re(mem_re),
    .o_mem_we(mem_we), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready), .i_mem_abort(mem_abort)
  );

  always #5 clk = ~clk;

  assign mem_ready = rsp_ready | late_ready;
  assign mem_abort = rsp_abort | late_ready;
  assign mem_rdata = late_ready ? 32'hBAD0BAD0 : rsp_rdata;

  // registered responder: ready one cycle after a strobe, aborts the 0x2000-0x2FFF window
  always @(posedge clk or posedge rst)
    if (rst) begin
      rsp_ready <= 1'b0;
      rsp_abort <= 1'b0;
      rsp_rdata <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[0] <= 32'h80017F80;
      mem[1] <= 32'hE3A04042;
    end else begin
      rsp_ready <= 1'b0;
      rsp_abort <= 1'b0;
      if ((mem_re || mem_we) && !mem_ready && !hang) begin
        rsp_ready <= 1'b1;
        rsp_abort <= mem_addr[31:12] == 20'h00002;
        rsp_rdata <= mem[mem_addr[5:2]];
        if (mem_we && mem_addr[31:12] != 20'h00002)
          for (int i = 0; i < 4; i++) if (mem_be[i]) mem[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end

  function automatic vec_t mk(input logic d, w, input mem_size_t sz, input logic sg,
                              input logic [31:0] a, wd, ba, input logic [3:0] be,
                              input logic [31:0] bw, rd, input logic ab);
    vec_t v;
    v.is_data = d; v.we = w; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
    v.bus_addr = ba; v.be = be; v.bus_wdata = bw; v.rdata = rd; v.abort = ab;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input vec_t v);
    if (v.is_data) begin
      data_req = 1'b1; data_we = v.we; data_size = v.size; data_signed = v.sgn;
      data_addr = v.addr; data_wdata = v.wdata;
    end else begin
      fetch_req = 1'b1; fetch_addr = v.addr;
    end
    q.push_back(v);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    logic prev = 1'b0;
    vec_t e;
    strobe_cycles = 0; t_strobe = -1; t_done = -1;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk); #1; n++;
      if (mem_re || mem_we) begin
        strobe_cycles++;
        if (!prev) begin
          t_strobe = n;
          chk("bus_addr", mem_addr, q[0].bus_addr);
          chk("bus_be", 32'(mem_be), 32'(q[0].be));
          chk("bus_re", 32'(mem_re), 32'(!q[0].we));
          chk("bus_we", 32'(mem_we), 32'(q[0].we));
          if (q[0].we) chk("bus_wdata", mem_wdata, q[0].bus_wdata);
          chk("ready_low_at_strobe", 32'(mem_ready), 32'd0);
        end
      end
      prev = mem_re || mem_we;
      if (data_done || fetch_done) begin
        e = q.pop_front();
        t_done = n;
        chk("done_port", 32'(data_done), 32'(e.is_data));
        chk("done_single", 32'(data_done && fetch_done), 32'd0);
        chk("rdata", e.is_data ? data_rdata : fetch_rdata, e.rdata);
        chk("abort", 32'(e.is_data ? data_abort : fetch_abort), 32'(e.abort));
        if (e.abort) chk("abort_addr", abort_addr, e.addr);
        if (data_done) data_req = 1'b0;
        if (fetch_done) fetch_req = 1'b0;
      end
    end
    if (q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout: %0d transactions pending after %0d cycles, expected 0", q.size(), budget);
      q.delete();
      data_req = 1'b0; fetch_req = 1'b0;
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 0, SZ_HALF, 0, 32'h100, 0, 32'h100, 4'h3, 0, 32'h00007F80, 0);
    tbl[1]  = mk(1, 0, SZ_BYTE, 1, 32'h100, 0, 32'h100, 4'h1, 0, 32'hFFFFFF80, 0);
    tbl[2]  = mk(1, 0, SZ_BYTE, 0, 32'h101, 0, 32'h101, 4'h2, 0, 32'h0000007F, 0);
    tbl[3]  = mk(1, 0, SZ_BYTE, 1, 32'h103, 0, 32'h103, 4'h8, 0, 32'hFFFFFF80, 0);
    tbl[4]  = mk(1, 0, SZ_WORD, 0, 32'h101, 0, 32'h101, 4'hF, 0, 32'h8080017F, 0);
    tbl[5]  = mk(1, 0, SZ_WORD, 0, 32'h102, 0, 32'h102, 4'hF, 0, 32'h7F808001, 0);
    tbl[6]  = mk(1, 1, SZ_BYTE, 0, 32'h103, 32'h000000A5, 32'h103, 4'h8, 32'hA5A5A5A5, 0, 0);
    tbl[7]  = mk(1, 0, SZ_WORD, 0, 32'h100, 0, 32'h100, 4'hF, 0, 32'hA5017F80, 0);
    tbl[8]  = mk(1, 1, SZ_HALF, 0, 32'h107, 32'h1234BEEF, 32'h106, 4'hC, 32'hBEEFBEEF, 0, 0);
    tbl[9]  = mk(1, 0, SZ_WORD, 0, 32'h104, 0, 32'h104, 4'hF, 0, 32'hBEEF4042, 0);
    tbl[10] = mk(1, 1, SZ_WORD, 0, 32'h108, 32'h12345678, 32'h108, 4'hF, 32'h12345678, 0, 0);
    tbl[11] = mk(0, 0, SZ_WORD, 0, 32'h10A, 0, 32'h108, 4'hF, 0, 32'h12345678, 0);
    tbl[12] = mk(1, 0, SZ_HALF, 1, 32'h10A, 0, 32'h10A, 4'hC, 0, 32'h00001234, 0);
    tbl[13] = mk(1, 1, SZ_WORD, 0, 32'h2000, 32'hCAFEF00D, 32'h2000, 4'hF, 32'hCAFEF00D, 0, 1);
    tbl[14] = mk(0, 0, SZ_WORD, 0, 32'h2000, 0, 32'h2000, 4'hF, 0, 0, 1);
    tbl[15] = mk(1, 0, SZ_BYTE, 1, 32'h2005, 0, 32'h2005, 4'h2, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_re_we", {mem_re, mem_we}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_be_wdata", {mem_be, mem_wdata[27:0]}, 0);
    chk("reset_done_abort", {fetch_done, data_done, fetch_abort, data_abort}, 0);
    chk("reset_abort_addr", abort_addr, 0);
    rst = 1'b0;

    issue(mk(1, 0, SZ_WORD, 0, 32'h104, 0, 32'h104, 4'hF, 0, 32'hE3A04042, 0));
    drain(10);
    chk("lat_strobe_cycle", t_strobe, 1);
    chk("lat_done_cycle", t_done, 3);
    chk("lat_re_cycles", strobe_cycles, 2);

    hang = 1'b1;
    issue(mk(1, 0, SZ_HALF, 1, 32'h102, 0, 32'h102, 4'hC, 0, 32'hFFFF8001, 0));
    repeat (3) @(posedge clk);
    #1 chk("rst_mid_bus_re", 32'(mem_re), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_re_we", {mem_re, mem_we}, 0);
    chk("rst_async_addr_be", {mem_addr[27:0], mem_be}, 0);
    chk("rst_async_rdata", data_rdata, 0);
    data_req = 1'b0;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    hang = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_no_done", {data_done, fetch_done, mem_re}, 0);
    end
    issue(mk(1, 0, SZ_HALF, 1, 32'h102, 0, 32'h102, 4'hC, 0, 32'hFFFF8001, 0));
    drain(10);

    for (int i = 0; i < 16; i++) begin
      issue(tbl[i]);
      drain(10);
      chk("tbl_strobe_cycles", strobe_cycles, 2);
    end

    issue(mk(1, 0, SZ_WORD, 0, 32'h108, 0, 32'h108, 4'hF, 0, 32'h12345678, 0));
    issue(mk(0, 0, SZ_WORD, 0, 32'h104, 0, 32'h104, 4'hF, 0, 32'hBEEF4042, 0));
    drain(20);
    chk("arb_fetch_strobe_cycle", t_strobe, 4);
    chk("arb_fetch_done_cycle", t_done, 6);
    chk("arb_total_strobes", strobe_cycles, 4);

    hang = 1'b1;
    issue(mk(1, 0, SZ_WORD, 0, 32'h100, 0, 32'h100, 4'hF, 0, 0, 1));
    drain(40);
    chk("tmo_done_cycle", t_done, 17);
    chk("tmo_re_cycles", strobe_cycles, 16);
    late_ready = 1'b1;
    hang = 1'b0;
    issue(mk(1, 0, SZ_WORD, 0, 32'h108, 0, 32'h108, 4'hF, 0, 32'h12345678, 0));
    @(posedge clk); #1;
    chk("late_ready_no_strobe", {mem_re, mem_we}, 0);
    chk("late_ready_no_done", {data_done, fetch_done}, 0);
    late_ready = 1'b0;
    drain(10);
    chk("late_next_done_cycle", t_done, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end
endmodule
